apb_slave: RTL and testbench

APB_SLAVE -- requirements
Module: apb_slave

---
 rtl/apb_arch_pkg.sv | 22 ++
 rtl/apb_slave_mem.sv | 38 +++
 rtl/apb_slave.sv | 136 +++++++++++++
 tb/tb_apb_slave.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arch_pkg.sv
// Shared APB architecture definitions: bus widths, FSM state encoding and the
// address error decode used by both the slave and the master side.
package apb_arch_pkg;

  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_ADDR_WIDTH = 8;
  localparam int APB_STRB_WIDTH = APB_DATA_WIDTH / 8;

  typedef logic [1:0] apb_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Byte address is zero-extended to 32 bits by the caller so one decode fits
  // every ADDR_WIDTH up to 32.
  function automatic logic apb_addr_err(input logic [31:0] byte_addr,
                                        input int unsigned depth);
    return (byte_addr[1:0] != 2'b00) || ((byte_addr >> 2) >= depth);
  endfunction

endpackage

// File: rtl/apb_slave_mem.sv
// Word-organised storage with a byte-enable synchronous write port, a
// combinational read port and an asynchronous clear of every word.
module apb_slave_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int IDX_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [IDX_W-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [IDX_W-1:0]        raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave.sv
// APB slave with a fixed number of wait states in front of a one-cycle
// registered response; accesses are decoded against a word memory.
module apb_slave
  import apb_arch_pkg::*;
#(
  parameter int          DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int          ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int unsigned MEM_DEPTH   = 64,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sel,
  input  logic                    enable,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] strobe,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ready,
  output logic                    slverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  apb_state_t state, next_state;
  logic [3:0] wait_cnt;

  logic [ADDR_WIDTH-1:0] cap_addr;
  logic                  cap_write;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [STRB_W-1:0]     cap_strobe;
  logic                  cap_err;

  logic                  setup;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic                  acc_write;
  logic                  acc_err;
  logic                  load_resp;
  logic                  mem_we;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] fwd_rdata;

  // A new setup is accepted from IDLE and, for back-to-back traffic, from RESP.
  assign setup     = sel && !enable && (state == ST_IDLE || state == ST_RESP);
  assign acc_addr  = setup ? addr  : cap_addr;
  assign acc_write = setup ? write : cap_write;
  assign acc_err   = apb_addr_err(32'(acc_addr), MEM_DEPTH);

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (setup) next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (!sel) next_state = ST_IDLE;
        else if (enable && wait_cnt == WAIT_LAST) next_state = ST_RESP;
      end
      ST_RESP: begin
        if (setup) next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        else next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign load_resp = (next_state == ST_RESP);

  // The write lands on the edge that closes RESP, which is also the edge that
  // may load rdata for a following zero-wait read, so the read path is merged.
  assign mem_we = (state == ST_RESP) && cap_write && !cap_err;
  assign wr_idx = cap_addr[2 +: IDX_W];
  assign rd_idx = acc_addr[2 +: IDX_W];

  always_comb begin
    fwd_rdata = mem_rdata;
    if (mem_we && wr_idx == rd_idx) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (cap_strobe[b]) fwd_rdata[b*8 +: 8] = cap_wdata[b*8 +: 8];
      end
    end
  end

  apb_slave_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (int'(MEM_DEPTH)),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (wr_idx),
    .wdata (cap_wdata),
    .wstrb (cap_strobe),
    .raddr (rd_idx),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      cap_addr   <= '0;
      cap_write  <= 1'b0;
      cap_wdata  <= '0;
      cap_strobe <= '0;
      cap_err    <= 1'b0;
      ready      <= 1'b0;
      slverr     <= 1'b0;
      rdata      <= '0;
    end else begin
      state <= next_state;
      if (setup) begin
        cap_addr   <= addr;
        cap_write  <= write;
        cap_wdata  <= wdata;
        cap_strobe <= strobe;
        cap_err    <= acc_err;
      end
      if (state == ST_WAIT && next_state == ST_WAIT && sel && enable) begin
        wait_cnt <= wait_cnt + 4'd1;
      end else begin
        wait_cnt <= '0;
      end
      ready  <= load_resp;
      slverr <= load_resp && acc_err;
      rdata  <= (load_resp && !acc_write && !acc_err) ? fwd_rdata : '0;
    end
  end

endmodule

// File: tb/tb_apb_slave.sv
// Directed bench for apb_slave: three instances (1, 0 and 3 wait states) on a
// shared bus with one select line each.
module tb_apb_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sel;
  logic        enable;
  logic        write;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  strobe;
  logic [31:0] rdata [3];
  logic [2:0]  ready;
  logic [2:0]  slverr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  apb_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MEM_DEPTH(32), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .rst(rst), .sel(sel[0]), .enable(enable), .write(write), .addr(addr),
    .wdata(wdata), .strobe(strobe), .rdata(rdata[0]), .ready(ready[0]), .slverr(slverr[0]));

  apb_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MEM_DEPTH(64), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst), .sel(sel[1]), .enable(enable), .write(write), .addr(addr),
    .wdata(wdata), .strobe(strobe), .rdata(rdata[1]), .ready(ready[1]), .slverr(slverr[1]));

  apb_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MEM_DEPTH(64), .WAIT_CYCLES(3)) u_dut_w3 (
    .clk(clk), .rst(rst), .sel(sel[2]), .enable(enable), .write(write), .addr(addr),
    .wdata(wdata), .strobe(strobe), .rdata(rdata[2]), .ready(ready[2]), .slverr(slverr[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_setup(input int k, input logic wr, input logic [7:0] a,
                             input logic [31:0] d, input logic [3:0] s);
    sel    = 3'b000;
    sel[k] = 1'b1;
    enable = 1'b0;
    write  = wr;
    addr   = a;
    wdata  = d;
    strobe = s;
  endtask

  // Access phase; bus fields are scrambled to prove the slave uses its copy.
  task automatic finish_xfer(input int k, output logic [31:0] rd, output logic err,
                             output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    rd    = '0;
    err   = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    addr   = 8'($urandom_range(0, 255));
    wdata  = $urandom;
    strobe = 4'($urandom_range(0, 15));
    write  = 1'($urandom_range(0, 1));
    for (int i = 0; i < 32 && !done; i++) begin
      if (ready[k]) begin
        done = 1'b1;
        rd   = rdata[k];
        err  = slverr[k];
      end else begin
        waits++;
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL timeout_dut%0d observed=no_ready expected=ready", k);
    end
  endtask

  task automatic xfer(input int k, input logic wr, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic err,
                      output int waits);
    @(posedge clk); #1;
    drive_setup(k, wr, a, d, s);
    finish_xfer(k, rd, err, waits);
  endtask

  task automatic go_idle(input int k, input string tag);
    @(posedge clk); #1;
    sel    = 3'b000;
    enable = 1'b0;
    check({tag, "_ready_drop"}, 32'(ready[k]), 32'd0);
    check({tag, "_rdata_idle"}, rdata[k], 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          w;
    int          pulses;

    rst = 1'b1; sel = '0; enable = 1'b0; write = 1'b0;
    addr = '0; wdata = '0; strobe = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_ready%0d", k), 32'(ready[k]), 32'd0);
      check($sformatf("reset_slverr%0d", k), 32'(slverr[k]), 32'd0);
      check($sformatf("reset_rdata%0d", k), rdata[k], 32'd0);
    end
    rst = 1'b0;

    // Full-word write then read, one wait state.
    xfer(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, rd, err, w);
    check("wr04_waits", 32'(w), 32'd1);
    check("wr04_slverr", 32'(err), 32'd0);
    check("wr04_rdata", rd, 32'd0);
    go_idle(0, "wr04");
    xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, rd, err, w);
    check("rd04_waits", 32'(w), 32'd1);
    check("rd04_rdata", rd, 32'hDEADBEEF);
    check("rd04_slverr", 32'(err), 32'd0);
    go_idle(0, "rd04");

    // Partial strobe merge.
    xfer(0, 1'b1, 8'h08, 32'h11223344, 4'hF, rd, err, w);
    go_idle(0, "pre08");
    xfer(0, 1'b1, 8'h08, 32'hAABBCCDD, 4'h3, rd, err, w);
    check("wr08_strb_slverr", 32'(err), 32'd0);
    go_idle(0, "wr08");
    xfer(0, 1'b0, 8'h08, 32'h0, 4'hF, rd, err, w);
    check("rd08_merge", rd, 32'h1122CCDD);
    go_idle(0, "rd08");

    // Error decode: beyond depth, misaligned read, misaligned write.
    xfer(0, 1'b0, 8'hFC, 32'h0, 4'h0, rd, err, w);
    check("rdFC_waits", 32'(w), 32'd1);
    check("rdFC_slverr", 32'(err), 32'd1);
    check("rdFC_rdata", rd, 32'd0);
    go_idle(0, "rdFC");
    xfer(0, 1'b0, 8'h06, 32'h0, 4'h0, rd, err, w);
    check("rd06_slverr", 32'(err), 32'd1);
    check("rd06_rdata", rd, 32'd0);
    go_idle(0, "rd06");
    xfer(0, 1'b1, 8'h05, 32'hFFFFFFFF, 4'hF, rd, err, w);
    check("wr05_slverr", 32'(err), 32'd1);
    go_idle(0, "wr05");
    xfer(0, 1'b1, 8'h04, 32'h0, 4'h0, rd, err, w);
    check("wr04_nostrb_slverr", 32'(err), 32'd0);
    go_idle(0, "wr04s0");
    xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, rd, err, w);
    check("rd04_unchanged", rd, 32'hDEADBEEF);
    check("rd04_unchanged_slverr", 32'(err), 32'd0);
    go_idle(0, "rd04b");

    // Access phase without setup is ignored.
    @(posedge clk); #1;
    sel = 3'b001; enable = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready[0]) pulses++;
    end
    check("enable_only_pulses", 32'(pulses), 32'd0);
    sel = 3'b000; enable = 1'b0;

    // Back-to-back write/read, zero wait states.
    xfer(1, 1'b1, 8'h10, 32'h5A5A0F0F, 4'hF, rd, err, w);
    check("b2b0_wr_waits", 32'(w), 32'd0);
    xfer(1, 1'b0, 8'h10, 32'h0, 4'h0, rd, err, w);
    check("b2b0_rd_waits", 32'(w), 32'd0);
    check("b2b0_rd_data", rd, 32'h5A5A0F0F);
    go_idle(1, "b2b0");

    // Back-to-back write/read, three wait states.
    xfer(2, 1'b1, 8'h10, 32'hC3C3A5A5, 4'hF, rd, err, w);
    check("b2b3_wr_waits", 32'(w), 32'd3);
    xfer(2, 1'b0, 8'h10, 32'h0, 4'h0, rd, err, w);
    check("b2b3_rd_waits", 32'(w), 32'd3);
    check("b2b3_rd_data", rd, 32'hC3C3A5A5);
    go_idle(2, "b2b3");

    // Reset while ready is high drops outputs without waiting for a clock.
    xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, rd, err, w);
    check("rd04_pre_rst", rd, 32'hDEADBEEF);
    rst = 1'b1;
    #1;
    check("async_rst_ready", 32'(ready[0]), 32'd0);
    check("async_rst_rdata", rdata[0], 32'd0);
    sel = 3'b000; enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, rd, err, w);
    check("rd04_cleared", rd, 32'd0);
    go_idle(0, "rd04c");

    // Reset during WAIT of a write, then setup in the first cycle after release.
    @(posedge clk); #1;
    drive_setup(2, 1'b1, 8'h0C, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_wait_ready", 32'(ready[2]), 32'd0);
    check("rst_wait_slverr", 32'(slverr[2]), 32'd0);
    check("rst_wait_rdata", rdata[2], 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive_setup(2, 1'b0, 8'h0C, 32'h0, 4'h0);
    finish_xfer(2, rd, err, w);
    check("rd0C_after_rst_waits", 32'(w), 32'd3);
    check("rd0C_after_rst_data", rd, 32'd0);
    go_idle(2, "rd0C");

    // Master abort: sel drops in WAIT; no pulse and no write.
    @(posedge clk); #1;
    drive_setup(2, 1'b1, 8'h14, 32'h12345678, 4'hF);
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    sel = 3'b000; enable = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready[2]) pulses++;
    end
    check("abort_pulses", 32'(pulses), 32'd0);
    xfer(2, 1'b0, 8'h14, 32'h0, 4'h0, rd, err, w);
    check("abort_rd14_waits", 32'(w), 32'd3);
    check("abort_rd14_data", rd, 32'd0);
    go_idle(2, "rd14");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
